// File: rtl/priority_arbiter_pkg.sv
// Shared types and helpers for the registered priority arbiter.
package priority_arbiter_pkg;

  typedef enum logic {FIXED = 1'b0, ROUND_ROBIN = 1'b1} arb_mode_t;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Hold counter width; one bit minimum so a disabled limit still has a legal vector.
  function automatic int hold_width(input int max_hold);
    return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  endfunction

endpackage

// File: rtl/priority_arbiter_encoder.sv
// Combinational N-input priority encoder; the highest set index wins.
module priority_encoder_n #(
  parameter int NUM_INPUTS = 4,
  localparam int W = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req_i,
  output logic [W-1:0]          result_o,
  output logic                  valid_o
);

  // Ascending scan so the last set bit seen is the highest index.
  always_comb begin
    result_o = '0;
    valid_o  = |req_i;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      result_o = req_i[i] ? W'(i) : result_o;
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// Registered N-input arbiter: fixed or round-robin priority, grant locking and
// an optional maximum-hold limit that forces rotation to other requesters.
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter int        NUM_REQ  = 4,
  parameter arb_mode_t MODE     = ROUND_ROBIN,
  parameter int        MAX_HOLD = 0,
  localparam int       IW       = $clog2(NUM_REQ),
  localparam int       HW       = hold_width(MAX_HOLD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               valid
);

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0]      HOLD_SAT = (MAX_HOLD > 0) ? HW'(MAX_HOLD) : HW'(1);
  localparam logic [IW:0]        N_W      = (IW+1)'(NUM_REQ);

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d, last_q, last_d;
  logic [HW-1:0]       hold_q, hold_d;

  logic [NUM_REQ-1:0]  holder_oh_s, cand_s, rot_s;
  logic [IW-1:0]       offset_s, enc_idx_s, win_idx_s;
  logic [IW:0]         lshift_s, sum_s;
  logic                enc_valid_s, holder_req_s, others_s, limit_s, keep_s;

  assign holder_oh_s  = (state_q == GRANT) ? (ONE_HOT0 << idx_q) : '0;
  assign holder_req_s = |(req & holder_oh_s);
  assign others_s     = |(req & ~holder_oh_s);
  assign limit_s      = (MAX_HOLD > 0) && (hold_q == HOLD_SAT);
  assign keep_s       = holder_req_s && !(limit_s && others_s);

  // A holder at its limit is masked out; a dropped holder is already absent from req.
  assign cand_s   = (holder_req_s && limit_s) ? (req & ~holder_oh_s) : req;

  // Rotating by last puts index last-1 on top, so the encoder's descending
  // priority becomes the round-robin search order.
  assign offset_s = (MODE == ROUND_ROBIN) ? last_q : '0;
  assign lshift_s = N_W - {1'b0, offset_s};
  assign rot_s    = (cand_s >> offset_s) | (cand_s << lshift_s);

  priority_encoder_n #(.NUM_INPUTS(NUM_REQ)) u_enc (
    .req_i    (rot_s),
    .result_o (enc_idx_s),
    .valid_o  (enc_valid_s)
  );

  assign sum_s     = {1'b0, enc_idx_s} + {1'b0, offset_s};
  assign win_idx_s = (sum_s >= N_W) ? IW'(sum_s - N_W) : sum_s[IW-1:0];

  // Next-state: lock, forced or dropped-holder re-arbitration, or idle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, GRANT: begin
        if ((state_q == GRANT) && keep_s) begin
          hold_d = (hold_q < HOLD_SAT) ? (hold_q + HW'(1)) : hold_q;
        end else if (enc_valid_s) begin
          state_d = GRANT;
          idx_d   = win_idx_s;
          last_d  = win_idx_s;
          hold_d  = HW'(1);
        end else begin
          state_d = IDLE;
          idx_d   = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        last_d  = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign valid   = (state_q == GRANT);
  assign gnt_idx = idx_q;
  assign gnt     = (ONE_HOT0 << idx_q) & {NUM_REQ{valid}};

endmodule

// File: tb/tb_priority_arbiter.sv
// Self-checking bench: constant vectors, hand-written corner sequences and a
// randomized run against a rule-level reference model, over five configurations.
module tb_priority_arbiter;
  import priority_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] req_a [5];
  logic [3:0] gnt_fx, gnt_rr, gnt_mh;
  logic [4:0] gnt_r5;
  logic [7:0] gnt_r8;
  logic [1:0] idx_fx, idx_rr, idx_mh;
  logic [2:0] idx_r5, idx_r8;
  logic       v_fx, v_rr, v_mh, v_r5, v_r8;

  priority_arbiter #(.NUM_REQ(4), .MODE(FIXED), .MAX_HOLD(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .req(req_a[0][3:0]), .gnt(gnt_fx), .gnt_idx(idx_fx), .valid(v_fx));
  priority_arbiter #(.NUM_REQ(4), .MODE(ROUND_ROBIN), .MAX_HOLD(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_a[1][3:0]), .gnt(gnt_rr), .gnt_idx(idx_rr), .valid(v_rr));
  priority_arbiter #(.NUM_REQ(4), .MODE(ROUND_ROBIN), .MAX_HOLD(3)) u_mh (
    .clk(clk), .rst_n(rst_n), .req(req_a[2][3:0]), .gnt(gnt_mh), .gnt_idx(idx_mh), .valid(v_mh));
  priority_arbiter #(.NUM_REQ(5), .MODE(ROUND_ROBIN), .MAX_HOLD(0)) u_r5 (
    .clk(clk), .rst_n(rst_n), .req(req_a[3][4:0]), .gnt(gnt_r5), .gnt_idx(idx_r5), .valid(v_r5));
  priority_arbiter #(.NUM_REQ(8), .MODE(ROUND_ROBIN), .MAX_HOLD(0)) u_r8 (
    .clk(clk), .rst_n(rst_n), .req(req_a[4][7:0]), .gnt(gnt_r8), .gnt_idx(idx_r8), .valid(v_r8));

  int cfg_n  [5] = '{4, 4, 4, 5, 8};
  bit cfg_rr [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int cfg_mh [5] = '{0, 0, 3, 0, 0};

  // Reference model: owner, validity, last winner, consecutive cycles held.
  bit m_v [5];
  int m_idx [5];
  int m_last [5];
  int m_hold [5];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       v;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [7:0] act_gnt(input int k);
    case (k)
      0: return {4'b0000, gnt_fx};
      1: return {4'b0000, gnt_rr};
      2: return {4'b0000, gnt_mh};
      3: return {3'b000, gnt_r5};
      default: return gnt_r8;
    endcase
  endfunction

  function automatic logic [2:0] act_idx(input int k);
    case (k)
      0: return {1'b0, idx_fx};
      1: return {1'b0, idx_rr};
      2: return {1'b0, idx_mh};
      3: return idx_r5;
      default: return idx_r8;
    endcase
  endfunction

  function automatic logic act_v(input int k);
    case (k)
      0: return v_fx;
      1: return v_rr;
      2: return v_mh;
      3: return v_r5;
      default: return v_r8;
    endcase
  endfunction

  function automatic logic [7:0] all_mask(input int n);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic cmp(input string name, input int k, input logic [7:0] eg,
                     input logic [2:0] ei, input logic ev);
    logic [7:0] ag;
    logic [2:0] ai;
    logic       av;
    ag = act_gnt(k);
    ai = act_idx(k);
    av = act_v(k);
    n_cmp++;
    if (ag !== eg || ai !== ei || av !== ev) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b, expected gnt=%b idx=%0d valid=%b",
               name, ag, ai, av, eg, ei, ev);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 5; k++) begin
      m_v[k] = 1'b0; m_idx[k] = 0; m_last[k] = 0; m_hold[k] = 0;
    end
  endtask

  // One arbitration decision computed straight from the rules.
  task automatic mstep(input int k, input logic [7:0] r);
    int n, start, c;
    bit others, found;
    logic [7:0] elig;
    n = cfg_n[k];
    elig = r & all_mask(n);
    others = 1'b0;
    found = 1'b0;
    for (int i = 0; i < n; i++)
      if (m_v[k] && i != m_idx[k] && elig[i]) others = 1'b1;
    if (m_v[k] && elig[m_idx[k]] && !(cfg_mh[k] > 0 && m_hold[k] == cfg_mh[k] && others)) begin
      if (m_hold[k] < cfg_mh[k]) m_hold[k]++;
      return;
    end
    if (m_v[k]) elig[m_idx[k]] = 1'b0;
    start = cfg_rr[k] ? (m_last[k] + n - 1) % n : n - 1;
    m_v[k] = 1'b0; m_idx[k] = 0; m_hold[k] = 0;
    for (int s = 0; s < n; s++) begin
      c = (start - s + n) % n;
      if (!found && elig[c]) begin
        found = 1'b1;
        m_v[k] = 1'b1; m_idx[k] = c; m_last[k] = c; m_hold[k] = 1;
      end
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 5; k++) mstep(k, req_a[k]);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] eg;
    for (int k = 0; k < 5; k++) begin
      eg = m_v[k] ? (8'h01 << m_idx[k]) : 8'h00;
      cmp($sformatf("%s[%0d]", tag, k), k, eg, 3'(m_idx[k]), m_v[k]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) req_a[k] = 8'h00;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;
  endtask

  // Every holder drops for one cycle in turn; grants walk down and wrap with no gap.
  task automatic rr_rotation(input int k);
    int n, h, e;
    n = cfg_n[k];
    do_reset();
    req_a[k] = all_mask(n);
    tick();
    cmp($sformatf("rot_first_n%0d", n), k, 8'h01 << (n - 1), 3'(n - 1), 1'b1);
    for (int s = 1; s <= n; s++) begin
      h = n - s;
      e = (h - 1 + n) % n;
      req_a[k] = all_mask(n) & ~(8'h01 << h);
      tick();
      cmp($sformatf("rot_n%0d_step%0d", n, s), k, 8'h01 << e, 3'(e), 1'b1);
      req_a[k] = all_mask(n);
      tick();
      cmp($sformatf("rot_n%0d_lock%0d", n, s), k, 8'h01 << e, 3'(e), 1'b1);
    end
  endtask

  initial begin
    int exp_mh [10];
    exp_mh = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};

    //            req      gnt      idx    v
    tbl[0] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[1] = '{4'b0110, 4'b0100, 2'd2, 1'b1};
    tbl[2] = '{4'b1110, 4'b0100, 2'd2, 1'b1};
    tbl[3] = '{4'b1010, 4'b1000, 2'd3, 1'b1};
    tbl[4] = '{4'b1010, 4'b1000, 2'd3, 1'b1};
    tbl[5] = '{4'b0011, 4'b0010, 2'd1, 1'b1};
    tbl[6] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[7] = '{4'b0001, 4'b0001, 2'd0, 1'b1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_a[0] = {4'b0000, tbl[i].req};
      tick();
      cmp($sformatf("fixed_vec%0d", i), 0, {4'b0000, tbl[i].gnt}, {1'b0, tbl[i].idx}, tbl[i].v);
    end

    // Asynchronous reset in the middle of a grant, then normal arbitration on release.
    do_reset();
    req_a[0] = 8'h04;
    tick();
    cmp("pre_reset_grant", 0, 8'h04, 3'd2, 1'b1);
    rst_n = 1'b0;
    model_clear();
    #1;
    cmp("async_reset", 0, 8'h00, 3'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    cmp("post_reset_grant", 0, 8'h04, 3'd2, 1'b1);

    // Round-robin wrap from last=0.
    do_reset();
    req_a[1] = 8'h01;
    tick();
    cmp("wrap_idx0", 1, 8'h01, 3'd0, 1'b1);
    req_a[1] = 8'h09;
    tick();
    cmp("wrap_lock0", 1, 8'h01, 3'd0, 1'b1);
    req_a[1] = 8'h08;
    tick();
    cmp("wrap_to3", 1, 8'h08, 3'd3, 1'b1);

    rr_rotation(1);
    rr_rotation(3);
    rr_rotation(4);

    // Forced release with MAX_HOLD=3, then a lone requester keeps the grant.
    do_reset();
    req_a[2] = 8'h03;
    for (int c = 0; c < 10; c++) begin
      tick();
      cmp($sformatf("maxhold_c%0d", c), 2, 8'h01 << exp_mh[c], 3'(exp_mh[c]), 1'b1);
    end
    req_a[2] = 8'h02;
    for (int c = 0; c < 8; c++) begin
      tick();
      cmp($sformatf("maxhold_alone_c%0d", c), 2, 8'h02, 3'd1, 1'b1);
    end

    // Randomized traffic with sticky request vectors so locks and limits occur.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 5; k++)
        if ($urandom_range(0, 3) == 0) req_a[k] = 8'($urandom) & all_mask(cfg_n[k]);
      tick();
      check_model($sformatf("rand_c%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
